// File: rtl/st_packet_arbiter.sv
// Packet-granular Avalon-ST arbiter: NUM_REQ sinks share one source, whole packets at a time.
// Round-robin by default; define ST_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module st_packet_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [NUM_REQ-1:0]            st_sink_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] st_sink_data,
  input  logic [NUM_REQ-1:0]            st_sink_startofpacket,
  input  logic [NUM_REQ-1:0]            st_sink_endofpacket,
  input  logic [NUM_REQ-1:0]            st_sink_valid,
  input  logic                          st_source_ready,
  output logic [DATA_WIDTH-1:0]         st_source_data,
  output logic                          st_source_startofpacket,
  output logic                          st_source_endofpacket,
  output logic                          st_source_valid,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] winner;
  logic                 any_valid;
  logic                 xfer;
  logic [DATA_WIDTH-1:0] sink_data [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign sink_data[gi] = st_sink_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search upward from rr_ptr; explicit wrap keeps odd NUM_REQ in range.
  always_comb begin
    int                   cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_WIDTH'(cand);
      if (!any_valid && st_sink_valid[cand_idx]) begin
        any_valid = 1'b1;
        winner    = cand_idx;
      end
    end
  end

  always_comb begin
    st_sink_ready           = '0;
    st_source_data          = '0;
    st_source_startofpacket = 1'b0;
    st_source_endofpacket   = 1'b0;
    st_source_valid         = 1'b0;
    if (state_q == LOCKED) begin
      st_source_data               = sink_data[grant_idx_q];
      st_source_startofpacket      = st_sink_startofpacket[grant_idx_q];
      st_source_endofpacket        = st_sink_endofpacket[grant_idx_q];
      st_source_valid              = st_sink_valid[grant_idx_q];
      st_sink_ready[grant_idx_q]   = st_source_ready;
    end
  end

  assign xfer = st_source_valid && st_source_ready;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_idx_d = winner;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && st_source_endofpacket) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ST_ARB_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == LOCKED && xfer && st_source_endofpacket) begin
      rr_ptr_d = (grant_idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_st_packet_arbiter.sv
// Randomized bench for st_packet_arbiter: packet-level reference model plus per-requester
// sequence scoreboard on the downstream stream.
module tb_st_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    snk_ready;
  logic [N*DW-1:0] snk_data;
  logic [N-1:0]    snk_sop, snk_eop, snk_valid;
  logic            src_ready;
  logic [DW-1:0]   src_data;
  logic            src_sop, src_eop, src_valid;
  logic [1:0]      grant;
  logic            busy;

  st_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .st_sink_ready(snk_ready), .st_sink_data(snk_data),
    .st_sink_startofpacket(snk_sop), .st_sink_endofpacket(snk_eop),
    .st_sink_valid(snk_valid), .st_source_ready(src_ready),
    .st_source_data(src_data), .st_source_startofpacket(src_sop),
    .st_source_endofpacket(src_eop), .st_source_valid(src_valid),
    .grant_idx(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester-side traffic generators
  int beat [N];
  int len  [N];
  int seq  [N];
  int out_exp [N];
  logic [N-1:0] mask;
  int vprob, rprob;

  // reference model: -1 means no packet owns the output
  int owner, rr, gidx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      snk_valid[i] = mask[i] && ($urandom_range(99) < vprob);
      snk_data[i*DW +: DW] = 16'((i << 12) | (seq[i] & 'hFFF));
      snk_sop[i] = (beat[i] == 0);
      snk_eop[i] = (beat[i] == len[i] - 1);
    end
    src_ready = ($urandom_range(99) < rprob);
  endtask

  task automatic step();
    logic [N-1:0]  e_ready, acc;
    logic [DW-1:0] e_data;
    logic          e_valid, e_sop, e_eop;
    int            tag;
    @(negedge clk);
    e_ready = '0; e_data = '0; e_valid = 0; e_sop = 0; e_eop = 0;
    if (owner >= 0) begin
      e_valid = snk_valid[owner];
      e_data  = snk_data[owner*DW +: DW];
      e_sop   = snk_sop[owner];
      e_eop   = snk_eop[owner];
      e_ready[owner] = src_ready;
    end
    check_eq("src_valid", 32'(src_valid), 32'(e_valid));
    check_eq("src_data", 32'(src_data), 32'(e_data));
    check_eq("src_sop", 32'(src_sop), 32'(e_sop));
    check_eq("src_eop", 32'(src_eop), 32'(e_eop));
    check_eq("sink_ready", 32'(snk_ready), 32'(e_ready));
    check_eq("grant_idx", 32'(grant), 32'(gidx));
    check_eq("busy", 32'(busy), 32'(owner >= 0));
    if (src_valid && src_ready) begin
      tag = int'(src_data[15:12]);
      $display("xfer t=%0t req=%0d data=%h sop=%0b eop=%0b", $time, tag, src_data, src_sop, src_eop);
      if (tag < N) begin
        check_eq("stream_seq", 32'(src_data[11:0]), 32'(out_exp[tag]));
        out_exp[tag] = (out_exp[tag] + 1) & 'hFFF;
      end else begin
        check_eq("stream_tag", 32'(tag), 32'(owner));
      end
    end
    acc = snk_ready & snk_valid;
    // packet-level rules: grant the first valid requester at or after rr, release on eop
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && snk_valid[(rr + k) % N]) owner = (rr + k) % N;
      end
      if (owner >= 0) gidx = owner;
    end else if (snk_valid[owner] && src_ready && snk_eop[owner]) begin
`ifndef ST_ARB_FIXED_PRIORITY_EN
      rr = (owner + 1) % N;
`endif
      owner = -1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        seq[i]++;
        beat[i]++;
        if (beat[i] == len[i]) begin
          beat[i] = 0;
          len[i]  = $urandom_range(1, 4);
        end
      end
    end
    drive();
  endtask

  task automatic do_reset_mid_packet();
    int budget = 60;
    while (owner < 0 && budget > 0) begin
      step();
      budget--;
    end
    check_eq("lock_before_reset", 32'(owner >= 0), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(src_valid), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_ready", 32'(snk_ready), 32'd0);
    owner = -1; rr = 0; gidx = 0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    owner = -1; rr = 0; gidx = 0;
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; seq[i] = 1; out_exp[i] = 1; len[i] = $urandom_range(1, 4);
    end
    mask = '0; vprob = 100; rprob = 100;
    drive();
    #12 reset = 1'b0;

    // quiet inputs: idle outputs
    repeat (10) step();

    // lone requester 1, 3-beat packet, ready held high
    len[1] = 3;
    mask = 4'b0010;
    drive();
    repeat (8) step();

    // everyone valid, always ready: round-robin rotation
    mask = 4'b1111;
    for (int i = 0; i < N; i++) if (beat[i] == 0) len[i] = 1;
    drive();
    repeat (24) step();

    // valid gaps and downstream backpressure
    vprob = 60; rprob = 50;
    repeat (400) step();

    do_reset_mid_packet();
    repeat (200) step();

    vprob = 85; rprob = 80;
    do_reset_mid_packet();
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
